// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit adder/subtractor built from BLOCK-bit carry-lookahead
// groups. An input register captures conditioned operands, then one register
// layer per group resolves BLOCK result bits per cycle. Valid/ready
// handshake with whole-pipeline stall; carry, overflow and zero flags are
// registered alongside the result.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LAT = WIDTH / BLOCK;

  // One BLOCK-bit group: returns {carry into top bit, carry out, sum}.
  function automatic logic [BLOCK+1:0] cla_block(input logic [BLOCK-1:0] ga,
                                                 input logic [BLOCK-1:0] gb,
                                                 input logic             gc);
    logic [BLOCK-1:0] s;
    logic             c_cur;
    logic             c_top;
    logic             p;
    logic             g;
    c_cur = gc;
    c_top = gc;
    s     = '0;
    for (int i = 0; i < BLOCK; i++) begin
      p     = ga[i] ^ gb[i];
      g     = ga[i] & gb[i];
      s[i]  = p ^ c_cur;
      c_top = c_cur;
      c_cur = p ? c_cur : g;
    end
    return {c_top, c_cur, s};
  endfunction

  // Index 0 is the operand register; index k+1 holds the result after group k.
  logic [WIDTH-1:0] r_a_p   [LAT];
  logic [WIDTH-1:0] r_b_p   [LAT];
  logic [WIDTH-1:0] r_s_p   [LAT+1];
  logic             r_c_p   [LAT+1];
  logic             r_vld_p [LAT+1];
  logic             r_ovf;
  logic             r_zero;

  logic             w_adv;
  logic [BLOCK+1:0] w_res  [LAT];
  logic [WIDTH-1:0] w_s_nx [LAT];
  logic             w_ovf;
  logic             w_zero;

  // Group evaluation for every stage plus final-stage flag derivation.
  always_comb begin
    w_adv = !r_vld_p[LAT] | out_ready;
    for (int k = 0; k < LAT; k++) begin
      w_res[k]  = cla_block(r_a_p[k][k*BLOCK +: BLOCK],
                            r_b_p[k][k*BLOCK +: BLOCK], r_c_p[k]);
      w_s_nx[k] = r_s_p[k];
      w_s_nx[k][k*BLOCK +: BLOCK] = w_res[k][BLOCK-1:0];
    end
    w_ovf  = w_res[LAT-1][BLOCK+1] ^ w_res[LAT-1][BLOCK];
    w_zero = (w_s_nx[LAT-1] == '0);
  end

  // Pipeline advance: every stage moves together or the whole pipe holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_a_p[k] <= '0;
        r_b_p[k] <= '0;
      end
      for (int k = 0; k <= LAT; k++) begin
        r_s_p[k]   <= '0;
        r_c_p[k]   <= 1'b0;
        r_vld_p[k] <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      // operand capture: subtraction is a + ~b + 1, cin ignored
      r_a_p[0]   <= a;
      r_b_p[0]   <= sub ? ~b : b;
      r_c_p[0]   <= sub | cin;
      r_s_p[0]   <= '0;
      r_vld_p[0] <= in_valid;
      // operand skew: upper slices travel with the partial result
      for (int k = 0; k < LAT-1; k++) begin
        r_a_p[k+1] <= r_a_p[k];
        r_b_p[k+1] <= r_b_p[k];
      end
      // group stages: resolved slices and carry move one stage forward
      for (int k = 0; k < LAT; k++) begin
        r_s_p[k+1]   <= w_s_nx[k];
        r_c_p[k+1]   <= w_res[k][BLOCK];
        r_vld_p[k+1] <= r_vld_p[k];
      end
      // output stage flags
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld_p[LAT];
  assign z         = r_s_p[LAT];
  assign cout      = r_c_p[LAT];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector bench for pipelined_cla_adder: table of hand-computed
// results, a back-to-back stream, a backpressure window and a mid-flight
// asynchronous reset, all checked through an in-order scoreboard.
module tb_pipelined_cla_adder;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int LAT   = WIDTH / BLOCK;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;
  logic             zero;

  pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] z;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  exp_t sbq[$];
  exp_t drv_exp;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  bit   lat_chk  = 1'b1;
  bit   hold_v   = 1'b0;
  logic [18:0] hold_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    exp_t        r;
    logic [15:0] bx;
    logic [16:0] s;
    bx     = ms ? ~mb : mb;
    s      = {1'b0, ma} + {1'b0, bx} + {16'd0, (ms ? 1'b1 : mc)};
    r.z    = s[15:0];
    r.cout = s[16];
    r.ovf  = (ma[15] == bx[15]) && (s[15] != ma[15]);
    r.zero = (s[15:0] == 16'h0000);
    r.cyc  = 0;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record accepted ops, compare emitted results, check stalls.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("hold_stable", {13'd0, out_valid, z, cout, ovf, zero},
            {13'd0, 1'b1, hold_val[18:3], hold_val[2:0]});
      if (out_valid && !out_ready)
        chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=none", z);
        end else begin
          e = sbq.pop_front();
          chk("z",    {16'd0, z},       {16'd0, e.z});
          chk("cout", {31'd0, cout},    {31'd0, e.cout});
          chk("ovf",  {31'd0, ovf},     {31'd0, e.ovf});
          chk("zero", {31'd0, zero},    {31'd0, e.zero});
          if (lat_chk) chk("latency", cyc - e.cyc, LAT);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {z, cout, ovf, zero};
      if (in_valid && in_ready) begin
        e     = drv_exp;
        e.cyc = cyc + 1;
        sbq.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic ts, input exp_t te);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; sub = ts; drv_exp = te; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(nm, sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vec_t vt[12];
  exp_t te;
  int   n0;
  int   n;

  initial begin
    vt[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h4B4B, 1'b1, 1'b1, 1'b0};
    vt[10] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[11] = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z",         {16'd0, z},         32'd0);
    chk("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // directed table, one op at a time
    for (int i = 0; i < 12; i++) begin
      te = '{vt[i].z, vt[i].cout, vt[i].ovf, vt[i].zero, 0};
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, te);
      idle();
      drain("table_drain");
    end

    // back-to-back stream at full throughput
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    idle();
    drain("stream_drain");
    chk("stream_count", n_out - n0, 8);

    // backpressure window in the middle of a stream
    lat_chk = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [15:0] ra, rb;
          logic        rs;
          ra = 16'($urandom); rb = 16'($urandom);
          rs = 1'(i % 2);
          send(ra, rb, 1'b1, rs, model(ra, rb, 1'b1, rs));
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - n0, 10);

    // reset with operations in flight
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'(100 + i), 16'(7 * i), 1'b0, 1'b0, model(16'(100 + i), 16'(7 * i), 1'b0, 1'b0));
    idle();
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_z",         {16'd0, z},         32'd0);
    chk("midrst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    sbq.delete();
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    n0 = n_out;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    lat_chk = 1'b1;
    send(16'd1, 16'd2, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0, 1'b0, 0});
    idle();
    drain("post_rst_drain");
    chk("post_rst_count", n_out - n0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
